mul_seq_ctrl: RTL and testbench

Multi-cycle sequencer for shift-add multiplication. It accepts one operand pair per transaction over a valid/ready handshake and resolves signs into magnitudes. It then iterates one multiplier bit per clock, MSB first, and presents the 2n-bit product over an output valid/ready handshake. It serves area-constrained configurations where the single-cycle n-stage adder chain is too large or too slow. The result is bit-identical to the combinational multiplier for the same a, b and sign.

---
 rtl/mul_seq_ctrl_pkg.sv | 15 +
 rtl/mul_seq_ctrl_if.sv | 27 ++
 rtl/mul_seq_ctrl_cond_negate.sv | 13 +
 rtl/mul_seq_ctrl.sv | 113 +++++++++++
 tb/tb_mul_seq_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mul_seq_ctrl_pkg.sv
// rtl/mul_seq_ctrl_pkg.sv - shared width default, state encoding and counter sizing
package mul_seq_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] MSC_IDLE = 2'd0;
    localparam logic [1:0] MSC_BUSY = 2'd1;
    localparam logic [1:0] MSC_DONE = 2'd2;

    // Iteration counter width: enough to hold n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// rtl/mul_seq_ctrl_if.sv - operand/result handshake bundle for the sequential multiplier
interface mul_seq_ctrl_if
    import mul_seq_ctrl_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           sign;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] prod;
    logic           busy;

    modport slave (
        input  in_valid, a, b, sign, flush, out_ready,
        output in_ready, out_valid, prod, busy
    );

    modport master (
        output in_valid, a, b, sign, flush, out_ready,
        input  in_ready, out_valid, prod, busy
    );
endinterface

// File: rtl/mul_seq_ctrl_cond_negate.sv
// rtl/mul_seq_ctrl_cond_negate.sv - two's complement negate when enabled, pass-through otherwise
module cond_negate #(
    parameter int W = 8
) (
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    // Negation wraps modulo 2^W, so the most negative value maps to its unsigned magnitude
    always_comb begin
        dout = en ? (~din + W'(1)) : din;
    end
endmodule

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - shift-add multiplier sequencer, one multiplier bit per clock, MSB first
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_seq_ctrl_if.slave bus
);
    localparam int CW = cnt_width(N);

    logic [1:0]     state_q, state_d;
    logic [N-1:0]   av_q, av_d;
    logic [N-1:0]   bv_q, bv_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           s_q, s_d;
    logic [2*N-1:0] prod_q, prod_d;

    logic           a_neg, b_neg;
    logic [N-1:0]   a_mag, b_mag;
    logic [2*N-1:0] nxt;
    logic [2*N-1:0] prod_signed;

    // Operand signs are only meaningful in signed mode
    always_comb begin
        a_neg = bus.sign & bus.a[N-1];
        b_neg = bus.sign & bus.b[N-1];
    end

    cond_negate #(.W(N)) u_neg_a (.en(a_neg), .din(bus.a), .dout(a_mag));
    cond_negate #(.W(N)) u_neg_b (.en(b_neg), .din(bus.b), .dout(b_mag));

    // One shift-add step: double the partial sum and add av when the current multiplier bit is set
    always_comb begin
        nxt = (acc_q << 1) + (bv_q[N-1] ? {{N{1'b0}}, av_q} : {(2*N){1'b0}});
    end

    cond_negate #(.W(2*N)) u_neg_p (.en(s_q), .din(nxt), .dout(prod_signed));

    // Next-state logic: accept in IDLE, iterate in BUSY, hold result in DONE; flush overrides all
    always_comb begin
        state_d = state_q;
        av_d    = av_q;
        bv_d    = bv_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        prod_d  = prod_q;
        if (bus.flush) begin
            state_d = MSC_IDLE;
        end else begin
            case (state_q)
                MSC_IDLE: begin
                    if (bus.in_valid) begin
                        s_d     = a_neg ^ b_neg;
                        av_d    = a_mag;
                        bv_d    = b_mag;
                        acc_d   = '0;
                        cnt_d   = CW'(N - 1);
                        state_d = MSC_BUSY;
                    end
                end
                MSC_BUSY: begin
                    acc_d = nxt;
                    bv_d  = bv_q << 1;
                    if (cnt_q == '0) begin
                        prod_d  = prod_signed;
                        state_d = MSC_DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                MSC_DONE: begin
                    if (bus.out_ready) begin
                        state_d = MSC_IDLE;
                    end
                end
                default: state_d = MSC_IDLE;
            endcase
        end
    end

    // State registers with asynchronous clear so a reset mid-operation never exposes partial results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MSC_IDLE;
            av_q    <= '0;
            bv_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            s_q     <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            av_q    <= av_d;
            bv_q    <= bv_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            prod_q  <= prod_d;
        end
    end

    // Handshake outputs decode directly from the registered state
    always_comb begin
        bus.in_ready  = (state_q == MSC_IDLE);
        bus.out_valid = (state_q == MSC_DONE);
        bus.busy      = (state_q == MSC_BUSY);
        bus.prod      = prod_q;
    end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - self-checking bench for mul_seq_ctrl
module tb_mul_seq_ctrl;
    localparam int N = 8;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    mul_seq_ctrl_if #(.N(N)) bus ();

    mul_seq_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic           sign;
        logic [2*N-1:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference product: plain integer multiplication, truncated to 2n bits
    function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic sign);
        longint sa, sb;
        sa = sign ? longint'($signed(a)) : longint'(a);
        sb = sign ? longint'($signed(b)) : longint'(b);
        return 16'(sa * sb);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one pair when in_ready, then scramble the operand lines
    task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b, input logic sign);
        int w;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 40) begin
            step();
            w++;
        end
        chk("accept_wait", 64'(w < 40), 64'd1);
        bus.a = a;
        bus.b = b;
        bus.sign = sign;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.a = N'($urandom);
        bus.b = N'($urandom);
        bus.sign = 1'($urandom);
    endtask

    // Count edges after the accept edge until out_valid is seen
    task automatic wait_done(output logic [2*N-1:0] p, output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        p = bus.prod;
    endtask

    logic [2*N-1:0] p, last_prod, exp;
    int             lat;
    logic [N-1:0]   ra, rb;
    logic           rs;
    int             hold;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.sign = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;

        vecs[0] = '{8'd3,   8'd5,   1'b0, 16'h000F};
        vecs[1] = '{8'hFD,  8'h05,  1'b1, 16'hFFF1};
        vecs[2] = '{8'h80,  8'h80,  1'b1, 16'h4000};
        vecs[3] = '{8'h80,  8'h01,  1'b1, 16'hFF80};
        vecs[4] = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
        vecs[5] = '{8'hFF,  8'hFF,  1'b1, 16'h0001};
        vecs[6] = '{8'h00,  8'h00,  1'b0, 16'h0000};
        vecs[7] = '{8'h00,  8'hFF,  1'b1, 16'h0000};

        #12;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_prod", 64'(bus.prod), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Directed table
        for (int i = 0; i < 8; i++) begin
            accept(vecs[i].a, vecs[i].b, vecs[i].sign);
            chk($sformatf("vec%0d_busy", i), 64'(bus.busy), 64'd1);
            wait_done(p, lat);
            chk($sformatf("vec%0d_prod", i), 64'(p), 64'(vecs[i].exp));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(N));
            chk($sformatf("vec%0d_done_in_ready", i), 64'(bus.in_ready), 64'd0);
            step();
            chk($sformatf("vec%0d_back_idle", i), 64'(bus.in_ready), 64'd1);
            last_prod = vecs[i].exp;
        end

        // Backpressure: hold result five cycles while ignored pairs are offered
        bus.out_ready = 1'b0;
        accept(8'd3, 8'd5, 1'b0);
        wait_done(p, lat);
        chk("bp_lat", 64'(lat), 64'(N));
        for (int k = 0; k < 5; k++) begin
            bus.a = 8'd7;
            bus.b = 8'd7;
            bus.in_valid = k[0];
            step();
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_prod", 64'(bus.prod), 64'h000F);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("bp_release_idle", 64'(bus.in_ready), 64'd1);
        accept(8'd12, 8'd11, 1'b0);
        wait_done(p, lat);
        chk("bp_next_prod", 64'(p), 64'd132);
        step();
        last_prod = 16'd132;

        // Flush on the 4th BUSY edge
        accept(8'd9, 8'd9, 1'b0);
        repeat (3) step();
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_idle", 64'(bus.in_ready), 64'd1);
        chk("flush_busy", 64'(bus.busy), 64'd0);
        chk("flush_prod", 64'(bus.prod), 64'(last_prod));
        hold = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.out_valid === 1'b1) hold++;
            step();
        end
        chk("flush_no_valid", 64'(hold), 64'd0);
        accept(8'd2, 8'd2, 1'b0);
        wait_done(p, lat);
        chk("flush_next_prod", 64'(p), 64'h0004);
        chk("flush_next_lat", 64'(lat), 64'(N));
        step();

        // Asynchronous reset mid-BUSY
        accept(8'd6, 8'd6, 1'b0);
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_prod", 64'(bus.prod), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        accept(8'd6, 8'd7, 1'b0);
        wait_done(p, lat);
        chk("arst_next_prod", 64'(p), 64'h002A);
        chk("arst_next_lat", 64'(lat), 64'(N));
        step();

        // Randomised transactions with random result backpressure
        for (int i = 0; i < 40; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rs = 1'($urandom);
            if (i % 10 == 0) ra = 8'h80;
            exp = model(ra, rb, rs);
            bus.out_ready = 1'($urandom);
            accept(ra, rb, rs);
            wait_done(p, lat);
            chk($sformatf("rnd%0d_prod", i), 64'(p), 64'(exp));
            chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(N));
            if (bus.out_ready == 1'b0) begin
                hold = $urandom_range(1, 3);
                repeat (hold) step();
                chk($sformatf("rnd%0d_hold", i), 64'(bus.prod), 64'(exp));
                bus.out_ready = 1'b1;
            end
            step();
            chk($sformatf("rnd%0d_idle", i), 64'(bus.in_ready), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
